// File: rtl/tx_frame_buffer.sv
// Store-and-forward Tx frame FIFO placed in front of the MAC AXIS input.
// A frame is released only after its tlast beat has been written; an oversize frame is dropped whole.
module tx_frame_buffer #(
   parameter  int DATA_WIDTH  = 32,
   parameter  int DEPTH       = 512,
   localparam int DATA_NBYTES = DATA_WIDTH / 8,
   localparam int ADDR_WIDTH  = $clog2(DEPTH)
) (
   input  logic                    xver_tx_clk,
   input  logic                    i_tx_reset,
   input  logic [DATA_WIDTH-1:0]   s00_axis_tdata,
   input  logic [DATA_NBYTES-1:0]  s00_axis_tkeep,
   input  logic                    s00_axis_tvalid,
   output logic                    s00_axis_tready,
   input  logic                    s00_axis_tlast,
   output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
   output logic [DATA_NBYTES-1:0]  m00_axis_tkeep,
   output logic                    m00_axis_tvalid,
   input  logic                    m00_axis_tready,
   output logic                    m00_axis_tlast,
   output logic [ADDR_WIDTH:0]     o_frame_count,
   output logic                    o_drop
);

   localparam int ENTRY_W = DATA_WIDTH + DATA_NBYTES + 1;
   localparam logic [ADDR_WIDTH:0] PTR_ONE  = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH:0] PTR_FULL = (ADDR_WIDTH+1)'(DEPTH);

   typedef enum logic {WRITE, DROP} wr_state_t;

   logic [ENTRY_W-1:0]  mem [DEPTH];
   logic [ENTRY_W-1:0]  ram_q;
   logic                ram_q_valid;
   logic [ADDR_WIDTH:0] wr_ptr, commit_ptr, rd_ptr, used;
   wr_state_t           state, state_nxt;
   logic                beat_in, full, wr_en, drop_now, commit;
   logic                out_free, stage_move, fetch, tlast_hs;

   // The buffer never back-pressures: oversize frames are discarded instead.
   assign s00_axis_tready = !i_tx_reset;
   assign beat_in         = s00_axis_tvalid && s00_axis_tready;
   assign used            = wr_ptr - rd_ptr;
   assign full            = (used == PTR_FULL);

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      state_nxt = state;
      wr_en     = 1'b0;
      drop_now  = 1'b0;
      commit    = 1'b0;
      case (state)
         WRITE: begin
            if (beat_in) begin
               if (full) begin
                  drop_now = 1'b1;
                  if (!s00_axis_tlast) state_nxt = DROP;
               end else begin
                  wr_en  = 1'b1;
                  commit = s00_axis_tlast;
               end
            end
         end
         DROP: begin
            if (beat_in && s00_axis_tlast) state_nxt = WRITE;
         end
         default: state_nxt = WRITE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge xver_tx_clk) begin
      if (i_tx_reset) begin
         state      <= WRITE;
         wr_ptr     <= '0;
         commit_ptr <= '0;
         o_drop     <= 1'b0;
      end else begin
         state  <= state_nxt;
         o_drop <= drop_now;
         if (drop_now)   wr_ptr <= commit_ptr;
         else if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
         if (commit)     commit_ptr <= wr_ptr + PTR_ONE;
      end
   end

   // NOTE: storage has no reset; the pointers alone say which entries are valid.
   always_ff @(posedge xver_tx_clk) begin
      if (wr_en) mem[wr_ptr[ADDR_WIDTH-1:0]] <= {s00_axis_tlast, s00_axis_tkeep, s00_axis_tdata};
      if (fetch) ram_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
   end

   // Two-stage read pipe (RAM register, output register) keeps a committed frame streaming at full rate.
   assign out_free   = !m00_axis_tvalid || m00_axis_tready;
   assign stage_move = ram_q_valid && out_free;
   assign fetch      = (rd_ptr != commit_ptr) && (!ram_q_valid || stage_move);
   assign tlast_hs   = m00_axis_tvalid && m00_axis_tready && m00_axis_tlast;

   always_ff @(posedge xver_tx_clk) begin
      if (i_tx_reset) begin
         rd_ptr          <= '0;
         ram_q_valid     <= 1'b0;
         m00_axis_tvalid <= 1'b0;
         m00_axis_tlast  <= 1'b0;
         m00_axis_tkeep  <= '0;
         m00_axis_tdata  <= '0;
      end else begin
         if (fetch) rd_ptr <= rd_ptr + PTR_ONE;
         ram_q_valid <= fetch || (ram_q_valid && !stage_move);
         if (stage_move) begin
            m00_axis_tvalid <= 1'b1;
            {m00_axis_tlast, m00_axis_tkeep, m00_axis_tdata} <= ram_q;
         end else if (m00_axis_tready) begin
            m00_axis_tvalid <= 1'b0;
         end
      end
   end

   always_ff @(posedge xver_tx_clk) begin
      if (i_tx_reset) begin
         o_frame_count <= '0;
      end else begin
         case ({commit, tlast_hs})
            2'b10:   o_frame_count <= o_frame_count + PTR_ONE;
            2'b01:   o_frame_count <= o_frame_count - PTR_ONE;
            default: o_frame_count <= o_frame_count;
         endcase
      end
   end

endmodule

// File: tb/tb_tx_frame_buffer.sv
// Directed bench for tx_frame_buffer (DEPTH=16): a scoreboard checks every output beat,
// and each scenario adds its own timing, drop and frame-count checks.
module tb_tx_frame_buffer;

   localparam int DW    = 32;
   localparam int NB    = 4;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   typedef struct packed {
      logic          last;
      logic [NB-1:0] keep;
      logic [DW-1:0] data;
   } beat_t;

   logic          clk = 1'b0;
   logic          i_tx_reset;
   logic [DW-1:0] s_tdata;
   logic [NB-1:0] s_tkeep;
   logic          s_tvalid, s_tready, s_tlast;
   logic [DW-1:0] m_tdata;
   logic [NB-1:0] m_tkeep;
   logic          m_tvalid, m_tready, m_tlast;
   logic [AW:0]   o_frame_count;
   logic          o_drop;

   int    checks = 0;
   int    failures = 0;
   int    hs_count = 0;
   int    drop_count = 0;
   int    rdy_mode = 0;
   beat_t exp_q[$];
   beat_t mon_e, prev_out;
   logic  prev_stall = 1'b0;

   always #5 clk = ~clk;

   tx_frame_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .xver_tx_clk     (clk),
      .i_tx_reset      (i_tx_reset),
      .s00_axis_tdata  (s_tdata),
      .s00_axis_tkeep  (s_tkeep),
      .s00_axis_tvalid (s_tvalid),
      .s00_axis_tready (s_tready),
      .s00_axis_tlast  (s_tlast),
      .m00_axis_tdata  (m_tdata),
      .m00_axis_tkeep  (m_tkeep),
      .m00_axis_tvalid (m_tvalid),
      .m00_axis_tready (m_tready),
      .m00_axis_tlast  (m_tlast),
      .o_frame_count   (o_frame_count),
      .o_drop          (o_drop)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // MAC ready pattern: 0 = always ready, 1 = toggle every cycle, 2 = random.
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       m_tready = 1'b1;
         1:       m_tready = ~m_tready;
         default: m_tready = 1'($urandom_range(0, 1));
      endcase
   end

   // Output monitor: scoreboard compare, stall-hold rule, handshake and drop counters.
   always @(negedge clk) begin
      if (prev_stall) begin
         check("stall_valid", 64'(m_tvalid), 64'(1));
         check("stall_hold", 64'({m_tlast, m_tkeep, m_tdata}), 64'(prev_out));
      end
      if (m_tvalid && m_tready) begin
         if (exp_q.size() == 0) begin
            check("extra_beat", 64'(exp_q.size()), 64'(1));
         end else begin
            mon_e = exp_q.pop_front();
            check("beat_data", 64'(m_tdata), 64'(mon_e.data));
            check("beat_keep", 64'(m_tkeep), 64'(mon_e.keep));
            check("beat_last", 64'(m_tlast), 64'(mon_e.last));
         end
         hs_count++;
      end
      prev_stall = m_tvalid && !m_tready && !i_tx_reset;
      prev_out   = {m_tlast, m_tkeep, m_tdata};
      if (o_drop) drop_count++;
   end

   task automatic send_beat(input logic [DW-1:0] d, input logic [NB-1:0] k, input logic l);
      s_tdata  = d;
      s_tkeep  = k;
      s_tlast  = l;
      s_tvalid = 1'b1;
      @(posedge clk);
      #1;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic send_frame(input int n, input logic [DW-1:0] base, input logic [NB-1:0] last_keep,
                             input bit expect_out);
      for (int i = 1; i <= n; i++) begin
         beat_t b;
         b.last = (i == n);
         b.keep = (i == n) ? last_keep : 4'hF;
         b.data = base + DW'(i);
         if (expect_out) exp_q.push_back(b);
         send_beat(b.data, b.keep, b.last);
      end
   endtask

   // Expects n consecutive valid beats with tlast on every period-th beat.
   task automatic observe_run(input int n, input int period);
      int w = 0;
      while (!m_tvalid && w < 50) begin
         @(negedge clk);
         w++;
      end
      check("run_start_timeout", 64'(w < 50), 64'(1));
      for (int k = 1; k <= n; k++) begin
         check("run_valid", 64'(m_tvalid), 64'(1));
         check("run_last", 64'(m_tlast), 64'(k % period == 0));
         @(negedge clk);
      end
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || o_frame_count != 0 || m_tvalid) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("drain_timeout", 64'(n < budget), 64'(1));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int hs_base, drop_base, peak, w;
      i_tx_reset = 1'b1;
      s_tvalid   = 1'b0;
      s_tlast    = 1'b0;
      s_tdata    = '0;
      s_tkeep    = '0;
      m_tready   = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_s_tready", 64'(s_tready), 64'(0));
      check("rst_m_tvalid", 64'(m_tvalid), 64'(0));
      check("rst_m_tlast", 64'(m_tlast), 64'(0));
      check("rst_m_tdata", 64'({m_tkeep, m_tdata}), 64'(0));
      check("rst_frame_count", 64'(o_frame_count), 64'(0));
      check("rst_drop", 64'(o_drop), 64'(0));
      @(posedge clk);
      #1;
      i_tx_reset = 1'b0;
      @(negedge clk);
      check("run_s_tready", 64'(s_tready), 64'(1));

      // 1) Max-size frame, latency and frame count
      send_frame(16, 32'hA100_0000, 4'h3, 1'b1);
      @(negedge clk);
      check("t1_valid_e0", 64'(m_tvalid), 64'(0));
      check("t1_count_1", 64'(o_frame_count), 64'(1));
      @(negedge clk);
      check("t1_valid_e1", 64'(m_tvalid), 64'(0));
      @(negedge clk);
      check("t1_valid_e2", 64'(m_tvalid), 64'(1));
      observe_run(16, 16);
      wait_drain(100);
      check("t1_count_0", 64'(o_frame_count), 64'(0));

      // 2) Three frames back-to-back
      hs_base = hs_count;
      fork
         begin
            send_frame(5, 32'hB100_0000, 4'hF, 1'b1);
            send_frame(5, 32'hB200_0000, 4'h1, 1'b1);
            send_frame(5, 32'hB300_0000, 4'h7, 1'b1);
         end
         observe_run(15, 5);
      join
      wait_drain(100);
      check("t2_beats", 64'(hs_count - hs_base), 64'(15));

      // 3) Oversize frame dropped, following frame intact
      hs_base   = hs_count;
      drop_base = drop_count;
      peak      = 0;
      for (int j = 1; j <= 20; j++) begin
         send_beat(32'hC000_0000 + DW'(j), 4'hF, j == 20);
         check("t3_drop_pulse", 64'(o_drop), 64'(j == 17));
         if (int'(o_frame_count) > peak) peak = int'(o_frame_count);
      end
      for (int j = 1; j <= 4; j++) begin
         beat_t b;
         b.last = (j == 4);
         b.keep = (j == 4) ? 4'h8 : 4'hF;
         b.data = 32'hC100_0000 + DW'(j);
         exp_q.push_back(b);
         send_beat(b.data, b.keep, b.last);
         check("t3_no_drop", 64'(o_drop), 64'(0));
         if (int'(o_frame_count) > peak) peak = int'(o_frame_count);
      end
      wait_drain(100);
      check("t3_drop_count", 64'(drop_count - drop_base), 64'(1));
      check("t3_beats", 64'(hs_count - hs_base), 64'(4));
      check("t3_peak_count", 64'(peak), 64'(1));

      // 4) Toggling MAC ready
      hs_base  = hs_count;
      rdy_mode = 1;
      send_frame(8, 32'hD000_0000, 4'h0, 1'b1);
      wait_drain(200);
      check("t4_beats", 64'(hs_count - hs_base), 64'(8));
      rdy_mode = 0;
      @(posedge clk);
      #1;

      // 5) Reset mid-frame while a frame drains
      send_frame(6, 32'hE100_0000, 4'hF, 1'b1);
      send_beat(32'hE200_0001, 4'hF, 1'b0);
      send_beat(32'hE200_0002, 4'hF, 1'b0);
      i_tx_reset = 1'b1;
      @(negedge clk);
      check("t5_tready_in_reset", 64'(s_tready), 64'(0));
      @(posedge clk);
      #1;
      i_tx_reset = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("t5_valid_after_reset", 64'(m_tvalid), 64'(0));
      check("t5_count_after_reset", 64'(o_frame_count), 64'(0));
      hs_base = hs_count;
      send_frame(3, 32'hE300_0000, 4'h3, 1'b1);
      wait_drain(100);
      check("t5_beats", 64'(hs_count - hs_base), 64'(3));

      // 6) 100 random frames with random MAC ready, paced to never overflow
      hs_base   = hs_count;
      drop_base = drop_count;
      rdy_mode  = 2;
      for (int f = 0; f < 100; f++) begin
         w = 0;
         while (o_frame_count > 1 && w < 1000) begin
            @(posedge clk);
            #1;
            w++;
         end
         check("t6_pace_timeout", 64'(w < 1000), 64'(1));
         for (int i = 1; i <= 7; i++) begin
            beat_t b;
            b.last = (i == 7);
            b.keep = 4'($urandom_range(0, 15));
            b.data = $urandom;
            exp_q.push_back(b);
            send_beat(b.data, b.keep, b.last);
         end
      end
      wait_drain(3000);
      check("t6_drops", 64'(drop_count - drop_base), 64'(0));
      check("t6_beats", 64'(hs_count - hs_base), 64'(700));
      rdy_mode = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
